// File: rtl/bcd_to_bin.sv
// bcd_to_bin: converts a 3-digit BCD value (hundreds 0-3) to binary using
// reverse double dabble, one bit per clock over 9 SHIFT cycles.
// The outputs bin/busy/done/err are registered one cycle behind the state.
// Optional build macro: BCD_TO_BIN_SAT_EN.
//   When defined, legal results above 255 saturate to 8'hFF and set err.
//   When undefined, such results wrap modulo 256 and err stays 0.
module bcd_to_bin (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] hunds,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [9:0] bcd;
  logic [8:0] result;
  logic [3:0] cnt;
  logic       bad;
  logic [9:0] bcd_next;
  logic [8:0] result_next;
  logic       bad_in;

  // A BCD digit of 8 or more after a right shift must lose 3 (16/2 - 10/2).
  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  // Map the 9-bit result to {err, bin}.
  function automatic logic [8:0] fold(input logic [8:0] r);
`ifdef BCD_TO_BIN_SAT_EN
    return r[8] ? {1'b1, 8'hFF} : {1'b0, r[7:0]};
`else
    return r & 9'h0FF;
`endif
  endfunction

  assign bad_in = (tens > 4'd9) || (units > 4'd9);

  // One reverse-double-dabble step: shift {bcd,result} right, then correct digits.
  always_comb begin
    bcd_next      = {1'b0, bcd[9:1]};
    bcd_next[7:4] = dabble(bcd_next[7:4]);
    bcd_next[3:0] = dabble(bcd_next[3:0]);
    result_next   = {bcd[0], result[8:1]};
  end

  // Control FSM and conversion datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bcd    <= '0;
      result <= '0;
      cnt    <= '0;
      bad    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd    <= {hunds, tens, units};
            result <= '0;
            cnt    <= '0;
            bad    <= bad_in;
            state  <= bad_in ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          bcd    <= bcd_next;
          result <= result_next;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd8) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered outputs; bin/err load when the result is final and hold in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      if (state == IDLE && start) begin
        err <= 1'b0;
      end else if (state == DONE) begin
        if (bad) begin
          err <= 1'b1;
          bin <= 8'h00;
        end else begin
          {err, bin} <= fold(result);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin; expected values are hand-computed decimal
// conversions, with the saturating build selected by BCD_TO_BIN_SAT_EN.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] hunds = '0;
  logic [3:0] tens = '0;
  logic [3:0] units = '0;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  bcd_to_bin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .hunds (hunds),
    .tens  (tens),
    .units (units),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one conversion, wait (bounded) for done, check latency/result/busy.
  task automatic convert(input string tag, input logic [1:0] h, input logic [3:0] t,
                         input logic [3:0] u, input logic [7:0] eb, input logic ee,
                         input int elat);
    int lat;
    int bcnt;
    lat = 0;
    bcnt = 0;
    @(negedge clk);
    hunds = h; tens = t; units = u; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " bin"}, bin, eb);
    check({tag, " err"}, err, ee);
    check({tag, " busy cycles"}, bcnt, elat);
    @(negedge clk);
    check({tag, " busy after"}, busy, 0);
    check({tag, " done after"}, done, 0);
    check({tag, " bin hold"}, bin, eb);
  endtask

  initial begin
    int dcnt;
    logic [7:0] dbin;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset bin", bin, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    rst_n = 1'b1;

    // Legal conversions
    convert("123", 2'd1, 4'd2, 4'd3, 8'd123, 1'b0, 10);
    convert("255", 2'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 10);
    convert("000", 2'd0, 4'd0, 4'd0, 8'h00, 1'b0, 10);
    convert("199", 2'd1, 4'd9, 4'd9, 8'd199, 1'b0, 10);
    convert("087", 2'd0, 4'd8, 4'd7, 8'd87, 1'b0, 10);
`ifdef BCD_TO_BIN_SAT_EN
    convert("399", 2'd3, 4'd9, 4'd9, 8'hFF, 1'b1, 10);
    convert("256", 2'd2, 4'd5, 4'd6, 8'hFF, 1'b1, 10);
`else
    convert("399", 2'd3, 4'd9, 4'd9, 8'd143, 1'b0, 10);
    convert("256", 2'd2, 4'd5, 4'd6, 8'd0, 1'b0, 10);
`endif

    // Illegal digits
    convert("0/10/4", 2'd0, 4'd10, 4'd4, 8'h00, 1'b1, 1);
    convert("0/4/15", 2'd0, 4'd4, 4'd15, 8'h00, 1'b1, 1);
    // err clears on the next accepted legal start
    convert("042", 2'd0, 4'd4, 4'd2, 8'd42, 1'b0, 10);

    // Start re-asserted mid-conversion with changing inputs is ignored
    dcnt = 0;
    dbin = 8'hAA;
    @(negedge clk);
    hunds = 2'd1; tens = 4'd0; units = 4'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcnt++;
        dbin = bin;
      end
      if (k == 2) begin
        start = 1'b1; hunds = 2'd3; tens = 4'd9; units = 4'd9;
      end
      if (k == 9) start = 1'b0;
    end
    check("ignored start done count", dcnt, 1);
    check("ignored start bin", dbin, 8'd100);

    // Reset in the middle of SHIFT aborts without a done pulse
    @(negedge clk);
    hunds = 2'd1; tens = 4'd2; units = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort bin", bin, 0);
    check("abort err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("abort done count", dcnt, 0);
    check("abort idle busy", busy, 0);
    check("abort idle bin", bin, 0);
    check("abort idle err", err, 0);
    convert("post abort 042", 2'd0, 4'd4, 4'd2, 8'd42, 1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
